// File: rtl/pacman_ctrl_sequencer.sv
// pacman_ctrl_sequencer: PIO command decode, game-state FSM and turn FIFO (in: clk reset ctrl_word frame_tick move_ok game_over; out: dir dir_strobe running state q_count overflow)
module pacman_ctrl_sequencer #(
  parameter int QDEPTH = 4,
  parameter int QAW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  ctrl_word,
  input  logic         frame_tick,
  input  logic         move_ok,
  input  logic         game_over,
  output logic [1:0]   dir,
  output logic         dir_strobe,
  output logic         running,
  output logic [1:0]   state,
  output logic [QAW:0] q_count,
  output logic         overflow
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
  state_t st, nxt;
  logic [7:0] last_tag;
  logic [1:0] mem [QDEPTH];
  logic [QAW-1:0] wr_ptr, rd_ptr, wr_base;
  logic [QAW:0] base_cnt;
  logic cmd, start, pause, resume, clr, go_over, restart, push_ok, pop, drop, wr_en;
  logic unused_bits;
  assign unused_bits = ^ctrl_word[23:7];
  assign state = st;
  always_comb begin
    cmd      = ctrl_word[31:24] != last_tag;
    start    = cmd && ctrl_word[3];
    pause    = cmd && ctrl_word[4];
    resume   = cmd && ctrl_word[5];
    clr      = cmd && ctrl_word[6];
    go_over  = st == RUN && game_over;
    restart  = start && !go_over;
    nxt      = go_over ? OVER : restart ? RUN : (st == RUN && pause) ? PAUSE : (st == PAUSE && resume) ? RUN : st;
    push_ok  = cmd && ctrl_word[2] && (st == RUN || st == PAUSE || restart);
    base_cnt = restart ? '0 : q_count;
    wr_base  = restart ? '0 : wr_ptr;
    pop      = !restart && st == RUN && frame_tick && move_ok && q_count != '0;
    drop     = push_ok && base_cnt == (QAW+1)'(QDEPTH) && !pop;
    wr_en    = push_ok && !drop;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_base] <= ctrl_word[1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      running    <= 1'b0;
      last_tag   <= '0;
      dir        <= '0;
      dir_strobe <= 1'b0;
      q_count    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      st         <= nxt;
      running    <= nxt == RUN;
      last_tag   <= ctrl_word[31:24];
      dir        <= restart ? 2'd0 : pop ? mem[rd_ptr] : dir;
      dir_strobe <= restart || pop;
      q_count    <= base_cnt + (QAW+1)'(wr_en) - (QAW+1)'(pop);
      wr_ptr     <= wr_base + QAW'(wr_en);
      rd_ptr     <= restart ? '0 : rd_ptr + QAW'(pop);
      overflow   <= drop || (overflow && !clr);
    end
  end
endmodule

// File: tb/tb_pacman_ctrl_sequencer.sv
// tb_pacman_ctrl_sequencer: directed plus random stimulus against a queue-based behavioural model
module tb_pacman_ctrl_sequencer;
  localparam int QDEPTH = 4;
  logic clk = 0, reset = 1, frame_tick = 0, move_ok = 0, game_over = 0;
  logic [31:0] ctrl_word = 0;
  logic [1:0] dir, state;
  logic dir_strobe, running, overflow;
  logic [2:0] q_count;
  int n_tests = 0, n_fail = 0;
  int m_state = 0, m_dir = 0, m_strobe = 0, m_ovf = 0, m_tag = 0;
  int q[$];
  int t = 0;

  pacman_ctrl_sequencer #(.QDEPTH(QDEPTH), .QAW(2)) dut (
    .clk(clk), .reset(reset), .ctrl_word(ctrl_word), .frame_tick(frame_tick),
    .move_ok(move_ok), .game_over(game_over), .dir(dir), .dir_strobe(dir_strobe),
    .running(running), .state(state), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int tag, input int d, input bit push, input bit start,
                                     input bit pause, input bit resume, input bit clr, input int junk);
    logic [16:0] j = 17'(junk);
    return {8'(tag), j, clr, resume, pause, start, push, 2'(d)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int tag = int'(ctrl_word[31:24]);
    bit cmd = tag != m_tag;
    bit st = cmd && ctrl_word[3], pz = cmd && ctrl_word[4], rs = cmd && ctrl_word[5];
    bit cl = cmd && ctrl_word[6], ps = cmd && ctrl_word[2];
    bit ending = m_state == 1 && game_over;
    bit restart = st && !ending;
    int ns;
    if (reset) begin
      q.delete();
      m_state = 0; m_dir = 0; m_strobe = 0; m_ovf = 0; m_tag = 0;
      return;
    end
    m_tag = tag;
    if (ending) ns = 3;
    else if (restart) ns = 1;
    else if (m_state == 1 && pz) ns = 2;
    else if (m_state == 2 && rs) ns = 1;
    else ns = m_state;
    m_strobe = 0;
    if (restart) begin
      q.delete();
      m_dir = 0;
      m_strobe = 1;
    end else if (m_state == 1 && frame_tick && move_ok && q.size() > 0) begin
      m_dir = q.pop_front();
      m_strobe = 1;
    end
    if (ps && (m_state == 1 || m_state == 2 || restart)) begin
      if (q.size() < QDEPTH) q.push_back(int'(ctrl_word[1:0]));
      else m_ovf = 1;
    end else if (cl) m_ovf = 0;
    if (ps && cl && q.size() < QDEPTH && m_ovf == 1) m_ovf = 0;
    m_state = ns;
  endtask

  task automatic cyc(input logic [31:0] w, input bit tk, input bit mv, input bit go, input bit rs);
    ctrl_word = w; frame_tick = tk; move_ok = mv; game_over = go; reset = rs;
    model_step();
    @(posedge clk);
    #1;
    chk("state", int'(state), m_state);
    chk("running", int'(running), int'(m_state == 1));
    chk("dir", int'(dir), m_dir);
    chk("dir_strobe", int'(dir_strobe), m_strobe);
    chk("q_count", int'(q_count), q.size());
    chk("overflow", int'(overflow), m_ovf);
  endtask

  initial begin
    logic [31:0] w;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_q", int'(q_count), 0);
    w = 32'h0100_0008; t = 1;
    cyc(w, 0, 0, 0, 0);
    chk("lit_start_state", int'(state), 1);
    chk("lit_start_strobe", int'(dir_strobe), 1);
    chk("lit_start_dir", int'(dir), 0);
    for (int i = 0; i < 10; i++) cyc(w, 0, 0, 0, 0);
    chk("lit_hold_strobe", int'(dir_strobe), 0);
    for (int d = 1; d <= 3; d++) begin
      t++; w = mk(t, d, 1, 0, 0, 0, 0, 0);
      cyc(w, 0, 0, 0, 0);
    end
    chk("lit_q3", int'(q_count), 3);
    cyc(w, 1, 0, 0, 0);
    chk("lit_nomove_q", int'(q_count), 3);
    cyc(w, 1, 1, 0, 0);
    chk("lit_pop_dir", int'(dir), 1);
    chk("lit_pop_strobe", int'(dir_strobe), 1);
    chk("lit_pop_q", int'(q_count), 2);
    for (int i = 0; i < 5; i++) begin
      t++; cyc(mk(t, i, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    end
    chk("lit_full_q", int'(q_count), 4);
    chk("lit_full_ovf", int'(overflow), 1);
    t++; cyc(mk(t, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0);
    chk("lit_clr_ovf", int'(overflow), 0);
    chk("lit_clr_q", int'(q_count), 4);
    t++; cyc(mk(t, 2, 1, 0, 0, 0, 0, 0), 1, 1, 0, 0);
    chk("lit_pp_q", int'(q_count), 4);
    chk("lit_pp_ovf", int'(overflow), 0);
    chk("lit_pp_strobe", int'(dir_strobe), 1);
    t++; w = mk(t, 0, 0, 0, 1, 0, 0, 0);
    cyc(w, 0, 0, 0, 0);
    chk("lit_pause", int'(state), 2);
    cyc(w, 1, 1, 0, 0);
    cyc(w, 1, 1, 1, 0);
    chk("lit_pause_q", int'(q_count), 4);
    chk("lit_pause_go", int'(state), 2);
    t++; w = mk(t, 0, 0, 0, 0, 1, 0, 0);
    cyc(w, 0, 0, 0, 0);
    chk("lit_resume", int'(state), 1);
    cyc(w, 0, 0, 1, 0);
    chk("lit_over", int'(state), 3);
    t++; cyc(mk(t, 1, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    chk("lit_over_q", int'(q_count), 4);
    t++; cyc(mk(t, 3, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0);
    chk("lit_rs_state", int'(state), 1);
    chk("lit_rs_q", int'(q_count), 1);
    chk("lit_rs_dir", int'(dir), 0);
    for (int i = 0; i < 2; i++) begin
      t++; cyc(mk(t, i, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    end
    chk("lit_pre_rst_q", int'(q_count), 3);
    cyc(mk(t, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1);
    chk("lit_rst_state", int'(state), 0);
    chk("lit_rst_q", int'(q_count), 0);
    chk("lit_rst_ovf", int'(overflow), 0);
    cyc(mk(t, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0);
    chk("lit_retag_state", int'(state), 1);
    for (int i = 0; i < 3000; i++) begin
      bit st, go;
      int r = int'($urandom_range(0, 99));
      if (r < 35) t = (t + 1) % 256;
      st = $urandom_range(0, 9) == 0;
      go = !st && $urandom_range(0, 24) == 0;
      w = mk(t, int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, st,
             !st && $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, int'($urandom));
      cyc(w, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, go, $urandom_range(0, 299) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
